// File: rtl/debounce_sync_pkg.sv
// Shared state codes and helpers for the debounce_sync block.
// The bench imports this package so both sides agree on the state encoding.
package debounce_sync_pkg;

   typedef enum logic [1:0] {
      S_LOW      = 2'd0,
      S_CHK_HIGH = 2'd1,
      S_HIGH     = 2'd2,
      S_CHK_LOW  = 2'd3
   } state_e;

   function automatic logic is_chk(input state_e s);
      return (s == S_CHK_HIGH) || (s == S_CHK_LOW);
   endfunction

endpackage

// File: rtl/debounce_sync_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Reusable on its own; both flops reset to RESET_VAL.
module sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s0_q;
   logic s1_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s0_q <= RESET_VAL;
         s1_q <= RESET_VAL;
      end else begin
         s0_q <= d;
         s1_q <= s0_q;
      end
   end

   assign q = s1_q;

endmodule

// File: rtl/debounce_sync.sv
// Synchronise and debounce a noisy level; q flips only after STABLE_CYCLES
// consecutive synchronised samples that differ from it, with one-cycle rise/fall pulses.
module debounce_sync
   import debounce_sync_pkg::*;
#(
   parameter int   CNT_W         = 4,
   parameter int   STABLE_CYCLES = 8,
   parameter logic RESET_VAL     = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       din,
   output logic       q,
   output logic       rise,
   output logic       fall,
   output logic       settling,
   output logic [1:0] dbg_state
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam state_e           RST_STATE = RESET_VAL ? S_HIGH : S_LOW;

   logic             sync1;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_q, q_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             settling_q, settling_d;

   sync2 #(.RESET_VAL(RESET_VAL)) u_sync2 (
      .clk   (clk),
      .reset (reset),
      .d     (din),
      .q     (sync1)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         S_LOW: begin
            if (sync1) begin
               state_d = S_CHK_HIGH;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         S_CHK_HIGH: begin
            // A single sample back at q throws away the candidate change.
            if (!sync1) begin
               state_d = S_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_HIGH;
               q_d     = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_HIGH: begin
            if (!sync1) begin
               state_d = S_CHK_LOW;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         S_CHK_LOW: begin
            if (sync1) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_LOW;
               q_d     = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = q_q ? S_HIGH : S_LOW;
            cnt_d   = '0;
         end
      endcase
      settling_d = is_chk(state_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= RST_STATE;
         cnt_q      <= '0;
         q_q        <= RESET_VAL;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         settling_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         q_q        <= q_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         settling_q <= settling_d;
      end
   end

   assign q         = q_q;
   assign rise      = rise_q;
   assign fall      = fall_q;
   assign settling  = settling_q;
   assign dbg_state = state_q;

endmodule
